// File: rtl/dmem_arbiter.sv
// Purpose : round-robin arbiter sharing one data_mem port between core (m0) and loader/DMA (m1).
// Latency : grant and memory mux are combinational (req -> gnt same cycle); read data 1 cycle after grant.
// Backpressure: a master holds req/we/addr/wdata until gnt; the loser simply waits, lock is bounded by MAX_HOLD.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   mN_req/we/lock/addr/wdata  request side of master N (N = 0, 1)
//   mN_gnt/rvalid/rdata   grant (same cycle), read-data pulse (next cycle), read data
//   mem_a/mem_d/mem_we    to data_mem, zero when nothing is granted
//   mem_spo               combinational read data from data_mem
//   cnt_gnt0/1, cnt_conflict  performance counters, only built with DMEM_ARB_PERF_EN
//
// Build option: define DMEM_ARB_PERF_EN to synthesize the performance counters,
// otherwise the counter outputs are tied to zero.

module dmem_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_spo,

    output logic [31:0]       cnt_gnt0,
    output logic [31:0]       cnt_gnt1,
    output logic [31:0]       cnt_conflict
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } own_t;

    own_t              state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    // Winner of the current cycle: win_vld says a grant is given, win_sel picks the master.
    logic win_vld;
    logic win_sel;

    logic              rvalid0_q, rvalid1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= 1'b0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            hold_q   <= hold_d;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration and next state
    // ------------------------------------------------------------------
    always_comb begin
        win_vld  = 1'b0;
        win_sel  = 1'b0;
        state_d  = IDLE;
        rr_ptr_d = rr_ptr_q;
        hold_d   = '0;

        // Reset wins over everything, so no grant (and no memory write) while it is high.
        if (reset) begin
            win_vld = 1'b0;
        end else if (state_q == OWN0 && m0_req && m0_lock &&
                     (!m1_req || hold_q < HOLD_MAX)) begin
            win_vld = 1'b1;
            win_sel = 1'b0;
        end else if (state_q == OWN1 && m1_req && m1_lock &&
                     (!m0_req || hold_q < HOLD_MAX)) begin
            win_vld = 1'b1;
            win_sel = 1'b1;
        end else if (m0_req && !m1_req) begin
            win_vld = 1'b1;
            win_sel = 1'b0;
        end else if (m1_req && !m0_req) begin
            win_vld = 1'b1;
            win_sel = 1'b1;
        end else if (m0_req && m1_req) begin
            win_vld = 1'b1;
            win_sel = rr_ptr_q;
        end

        if (win_vld) begin
            state_d  = win_sel ? OWN1 : OWN0;
            rr_ptr_d = ~win_sel;
            // Saturating at MAX_HOLD is enough: the lock test only asks "below MAX_HOLD?".
            if (state_q == state_d)
                hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
            else
                hold_d = HOLD_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Outputs: grants and memory port mux
    // ------------------------------------------------------------------
    always_comb begin
        m0_gnt = win_vld & ~win_sel;
        m1_gnt = win_vld &  win_sel;
        mem_a  = '0;
        mem_d  = '0;
        mem_we = 1'b0;
        if (win_vld) begin
            mem_a  = win_sel ? m1_addr  : m0_addr;
            mem_d  = win_sel ? m1_wdata : m0_wdata;
            mem_we = win_sel ? m1_we    : m0_we;
        end
        // rvalid is masked by reset so a reset in the cycle after a read grant kills the pulse.
        m0_rvalid = rvalid0_q & ~reset;
        m1_rvalid = rvalid1_q & ~reset;
        m0_rdata  = rdata0_q;
        m1_rdata  = rdata1_q;
    end

    // ------------------------------------------------------------------
    // Read return: capture mem_spo at the grant edge
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= m0_gnt & ~m0_we;
            rvalid1_q <= m1_gnt & ~m1_we;
            if (m0_gnt && !m0_we)
                rdata0_q <= mem_spo;
            if (m1_gnt && !m1_we)
                rdata1_q <= mem_spo;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] cnt_gnt0_q, cnt_gnt1_q, cnt_conflict_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_gnt0_q     <= '0;
            cnt_gnt1_q     <= '0;
            cnt_conflict_q <= '0;
        end else begin
            if (m0_gnt)
                cnt_gnt0_q <= cnt_gnt0_q + 32'd1;
            if (m1_gnt)
                cnt_gnt1_q <= cnt_gnt1_q + 32'd1;
            if (m0_req && m1_req)
                cnt_conflict_q <= cnt_conflict_q + 32'd1;
        end
    end

    assign cnt_gnt0     = cnt_gnt0_q;
    assign cnt_gnt1     = cnt_gnt1_q;
    assign cnt_conflict = cnt_conflict_q;
`else
    assign cnt_gnt0     = '0;
    assign cnt_gnt1     = '0;
    assign cnt_conflict = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose : directed bench for dmem_arbiter with a combinational-read memory model.
// Latency : inputs change 1 time unit after a rising edge, outputs are sampled 1 unit later.
// Backpressure: masters hold their request until the expected grant cycle.

module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic        m0_req, m0_we, m0_lock;
    logic [13:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_gnt, m0_rvalid;
    logic [31:0] m0_rdata;

    logic        m1_req, m1_we, m1_lock;
    logic [13:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_gnt, m1_rvalid;
    logic [31:0] m1_rdata;

    logic [13:0] mem_a;
    logic [31:0] mem_d;
    logic        mem_we;
    logic [31:0] mem_spo;

    logic [31:0] cnt_gnt0, cnt_gnt1, cnt_conflict;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] mem [0:16383];

    always #5 clk = ~clk;

    assign mem_spo = mem[mem_a];

    always @(posedge clk) begin
        if (mem_we)
            mem[mem_a] <= mem_d;
    end

    dmem_arbiter #(
        .ADDR_W  (14),
        .DATA_W  (32),
        .MAX_HOLD(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m0_req      (m0_req),
        .m0_we       (m0_we),
        .m0_lock     (m0_lock),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_gnt      (m0_gnt),
        .m0_rvalid   (m0_rvalid),
        .m0_rdata    (m0_rdata),
        .m1_req      (m1_req),
        .m1_we       (m1_we),
        .m1_lock     (m1_lock),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_gnt      (m1_gnt),
        .m1_rvalid   (m1_rvalid),
        .m1_rdata    (m1_rdata),
        .mem_a       (mem_a),
        .mem_d       (mem_d),
        .mem_we      (mem_we),
        .mem_spo     (mem_spo),
        .cnt_gnt0    (cnt_gnt0),
        .cnt_gnt1    (cnt_gnt1),
        .cnt_conflict(cnt_conflict)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [12:0] t4_exp;
    int          m1_done;
    logic [31:0] exp_conf, exp_g0, exp_g1;

    initial begin
        for (int i = 0; i < 16384; i++)
            mem[i] = 32'h0;
        mem[14'h0010] = 32'hDEADBEEF;
        mem[14'h0020] = 32'hA5A50020;
        for (int i = 0; i < 12; i++)
            mem[14'h0100 + i] = 32'hC0DE0000 + i;

        // ---------------- 1: reset with both masters requesting ----------------
        reset    = 1'b1;
        m0_req   = 1'b1; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = 14'h0; m0_wdata = 32'h0;
        m1_req   = 1'b1; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = 14'h0; m1_wdata = 32'h0;
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rst_gnt0",   m0_gnt,       0);
            chk("rst_gnt1",   m1_gnt,       0);
            chk("rst_memwe",  mem_we,       0);
            chk("rst_rv0",    m0_rvalid,    0);
            chk("rst_rv1",    m1_rvalid,    0);
            chk("rst_cg0",    cnt_gnt0,     0);
            chk("rst_cg1",    cnt_gnt1,     0);
            chk("rst_ccf",    cnt_conflict, 0);
        end
        reset = 1'b0;
        #1;
        chk("tie_gnt0", m0_gnt, 1);
        chk("tie_gnt1", m1_gnt, 0);
        step();
        m0_req = 1'b0;
        m1_req = 1'b0;

        // ---------------- 2: single m0 read ----------------
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 14'h0010;
        #1;
        chk("rd_gnt0",  m0_gnt, 1);
        chk("rd_mema",  mem_a,  32'h0010);
        chk("rd_memwe", mem_we, 0);
        step();
        m0_req = 1'b0;
        #1;
        chk("rd_rv0",    m0_rvalid, 1);
        chk("rd_rdata0", m0_rdata,  32'hDEADBEEF);
        chk("rd_rv1",    m1_rvalid, 0);
        chk("idle_mema", mem_a,     0);
        step();
        chk("rd_rv0_off",  m0_rvalid, 0);
        chk("rd_rdata_hold", m0_rdata, 32'hDEADBEEF);

        // ---------------- 3: alternating writes ----------------
        reset = 1'b1;
        step();
        reset = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 14'h0001; m0_wdata = 32'h11;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 14'h0002; m1_wdata = 32'h22;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("wr_gnt0",  m0_gnt, (i % 2 == 0) ? 1 : 0);
            chk("wr_gnt1",  m1_gnt, (i % 2 == 0) ? 0 : 1);
            chk("wr_memwe", mem_we, 1);
            chk("wr_mema",  mem_a,  (i % 2 == 0) ? 32'h1 : 32'h2);
            chk("wr_memd",  mem_d,  (i % 2 == 0) ? 32'h11 : 32'h22);
            step();
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
`ifdef DMEM_ARB_PERF_EN
        exp_conf = 32'd6; exp_g0 = 32'd3; exp_g1 = 32'd3;
`else
        exp_conf = 32'd0; exp_g0 = 32'd0; exp_g1 = 32'd0;
`endif
        #1;
        chk("wr_cnt_conf", cnt_conflict, exp_conf);
        chk("wr_cnt_g0",   cnt_gnt0,     exp_g0);
        chk("wr_cnt_g1",   cnt_gnt1,     exp_g1);
        chk("wr_mem1",     mem[14'h0001], 32'h11);
        chk("wr_mem2",     mem[14'h0002], 32'h22);
        chk("wr_no_rv0",   m0_rvalid,    0);
        step();

        // ---------------- 4: m1 locked burst, m0 joins on 2nd cycle ----------------
        t4_exp  = 13'b1111_0_1111_1111;   // bit c: 1 = m1 granted in cycle c, 0 = m0
        m1_done = 0;
        m0_we   = 1'b0;
        m0_lock = 1'b0;
        m0_addr = 14'h0020;
        for (int c = 0; c < 13; c++) begin
            m1_req  = 1'b1;
            m1_lock = 1'b1;
            m1_we   = 1'b0;
            m1_addr = 14'(14'h0100 + m1_done);
            if (c == 1)
                m0_req = 1'b1;
            #1;
            chk("brst_gnt1", m1_gnt, t4_exp[c]);
            chk("brst_gnt0", m0_gnt, !t4_exp[c]);
            if (c == 9) begin
                chk("brst_rv0",    m0_rvalid, 1);
                chk("brst_rdata0", m0_rdata,  32'hA5A50020);
            end
            if (t4_exp[c]) begin
                chk("brst_mema", mem_a, 32'h0100 + m1_done);
                m1_done++;
            end
            step();
            if (!t4_exp[c])
                m0_req = 1'b0;
        end
        chk("brst_rdata1", m1_rdata, 32'hC0DE000B);
        m1_req  = 1'b0;
        m1_lock = 1'b0;
        step();

        // ---------------- 5: m1 locked burst alone ----------------
        m1_done = 0;
        for (int c = 0; c < 12; c++) begin
            m1_req  = 1'b1;
            m1_lock = 1'b1;
            m1_addr = 14'(14'h0100 + m1_done);
            #1;
            chk("solo_gnt1", m1_gnt, 1);
            chk("solo_gnt0", m0_gnt, 0);
            m1_done++;
            step();
        end
        m1_req  = 1'b0;
        m1_lock = 1'b0;
        #1;
        chk("solo_end_gnt1", m1_gnt, 0);
        chk("solo_end_memwe", mem_we, 0);
        step();

        // ---------------- 6: reset right after a read grant ----------------
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 14'h0010;
        #1;
        chk("rr_gnt0", m0_gnt, 1);
        step();
        m0_req = 1'b0;
        reset  = 1'b1;
        #1;
        chk("rr_rv0_sup", m0_rvalid, 0);
        step();
        chk("rr_rv0_after", m0_rvalid, 0);
        chk("rr_rdata0",    m0_rdata,  0);
        reset  = 1'b0;
        m0_req = 1'b1;
        m1_req = 1'b1;
        #1;
        chk("rr_tie_gnt0", m0_gnt, 1);
        chk("rr_tie_gnt1", m1_gnt, 0);
        step();
        m0_req = 1'b0;
        m1_req = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data_mem port (14-bit word address, 32-bit data, combinational read `spo`, clocked write) between two requesters.
- Master 0 is the miniRV core load/store path. Master 1 is a loader/DMA/debug port.
- Sits between the masters and data_mem in the top level, and converts the raw memory port into a req/gnt/rvalid handshake per master.
- Arbitration is round-robin, with an optional bounded lock for bursts.

Parameters:
- ADDR_W, 14, word address width (data_mem `a`).
- DATA_W, 32, data width.
- MAX_HOLD, 8, max consecutive locked grants to one master while the other is requesting (≥1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  master 0 access request; held until granted.
- m0_we  in  1  master 0 write (1) / read (0).
- m0_lock  in  1  master 0 requests that the grant be kept next cycle.
- m0_addr  in  ADDR_W  master 0 word address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_gnt  out  1  master 0 granted this cycle; the access happens this cycle.
- m0_rvalid  out  1  master 0 read data valid, one cycle after a read grant.
- m0_rdata  out  DATA_W  master 0 read data.
- m1_*  same set as m0_* for master 1.
- mem_a  out  ADDR_W  to data_mem `a`.
- mem_d  out  DATA_W  to data_mem `d`.
- mem_we  out  1  to data_mem `we`.
- mem_spo  in  DATA_W  from data_mem `spo`.
- cnt_gnt0  out  32  grant count, master 0 (optional feature).
- cnt_gnt1  out  32  grant count, master 1 (optional feature).
- cnt_conflict  out  32  cycles with both masters requesting (optional feature).

Behaviour:
- Owner state: IDLE, OWN0, OWN1. The state holds the winner of the previous cycle; IDLE if no grant was given.
- Auxiliary state:
  - rr_ptr: master favoured on a tie. Reset value is 0.
  - hold_cnt: consecutive grants to the current owner, width clog2(MAX_HOLD+1), saturating.
- Grant decision is combinational each cycle (req → gnt in the same cycle). In priority order:
  1. Owner x requests with lock_x, and (the other master is idle or hold_cnt < MAX_HOLD) → grant x again.
  2. Exactly one master requests → grant it.
  3. Both request → grant rr_ptr.
  4. Otherwise → no grant.
- On each grant:
  - state ← OWNx.
  - rr_ptr ← the other master.
  - hold_cnt ← hold_cnt+1 if x was already the owner, else 1.
- With no grant: state ← IDLE, hold_cnt ← 0, rr_ptr unchanged.
- At most one gnt is high per cycle; the other master's gnt is 0.
- Memory port:
  - mem_a, mem_d and mem_we are muxed combinationally from the winner; mem_we = winner's we.
  - With no grant: mem_a=0, mem_d=0, mem_we=0.
- Reads:
  - A granted read (we=0) sets that master's rvalid=1 on the next cycle, with rdata = mem_spo registered at the grant edge.
  - rvalid is a 1-cycle pulse.
  - rdata holds its last value when rvalid=0.
- Writes: committed at the grant edge; no rvalid is generated.
- A master must keep req, we, addr and wdata stable until gnt. Dropping req before gnt withdraws the request with no side effect.
- A lock without req has no effect. Lock forced off by MAX_HOLD: the other master gets exactly one grant, then normal arbitration resumes.
- Reset:
  - state=IDLE, rr_ptr=0, hold_cnt=0.
  - gnt, rvalid, rdata and the counters all go to 0.
  - Reset asserted in the cycle after a read grant suppresses that rvalid.
  - Reset has priority over every event.
- No write-data width conversion; addresses are passed through unmodified.

Optional Feature:
- DMEM_ARB_PERF_EN defined:
  - cnt_gnt0 and cnt_gnt1 increment on each grant to their master.
  - cnt_conflict increments on each cycle with m0_req & m1_req.
  - All three are 32-bit, wrap modulo 2^32, and clear on reset.
- Not defined: the counters are not synthesized and the three outputs are tied to 0.

Test Plan:
1. Reset held high 2 cycles with both req=1 → all gnt, rvalid and mem_we are 0, counters are 0. After release, first tie → m0_gnt.
2. m0 read addr 0x0010, with memory holding 0xDEADBEEF → m0_gnt=1 and mem_a=0x0010 the same cycle; next cycle m0_rvalid=1 and m0_rdata=0xDEADBEEF; rvalid=0 the cycle after.
3. Both masters issue continuous unlocked writes (m0 to 0x0001 with data 0x11, m1 to 0x0002 with data 0x22) for 6 cycles → grants m0,m1,m0,m1,m0,m1, with mem_we=1 each cycle and the matching addr/data. With PERF_EN: cnt_conflict=6, cnt_gnt0=3, cnt_gnt1=3.
4. m1 locked burst of 12 reads; m0 requests from the burst's 2nd cycle → m1 gets 8 consecutive grants, m0 gets 1, then m1 resumes and completes its remaining 4.
5. m1 locked burst of 12 with m0 idle → 12 consecutive m1 grants, with no forced switch.
6. m0 read granted, then reset asserted the next cycle → m0_rvalid stays 0 and state returns to IDLE.
